// File: rtl/seq_detect_param.sv
// Parametrised Mealy sequence detector with a programmable pattern, overlap mode and a saturating match counter.
// Optional idle timeout that drops partial progress: define SEQ_DETECT_TIMEOUT_EN.
module seq_detect_param #(
  parameter int unsigned                  SYM_W    = 3,
  parameter int unsigned                  SEQ_LEN  = 4,
  parameter logic [SEQ_LEN*SYM_W-1:0]     PAT_INIT = 12'h530,
  parameter int unsigned                  OVERLAP  = 1,
  parameter int unsigned                  CNT_W    = 8,
  parameter int unsigned                  TIMEOUT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [SYM_W-1:0]              inp,
  input  logic                          pat_we,
  input  logic [$clog2(SEQ_LEN)-1:0]    pat_addr,
  input  logic [SYM_W-1:0]              pat_wdata,
  input  logic                          cnt_clr,
  output logic                          done,
  output logic [1:0]                    detect,
  output logic [$clog2(SEQ_LEN+1)-1:0]  progress,
  output logic [CNT_W-1:0]              match_cnt
);

  localparam int unsigned PW = $clog2(SEQ_LEN + 1);
  localparam int unsigned HL = SEQ_LEN - 1;

  logic [SYM_W-1:0] r_pat  [SEQ_LEN];
  logic [SYM_W-1:0] r_hist [HL];
  logic [PW-1:0]    r_k;
  logic [CNT_W-1:0] r_cnt;

  logic [SYM_W-1:0] w_s [SEQ_LEN];
  logic [SEQ_LEN:0] w_ok;
  logic [PW-1:0]    w_adv;
  logic [PW-1:0]    w_border;
  logic [PW-1:0]    w_k_nxt;
  logic             w_hist_clr;
  logic             w_hist_shift;
  logic             w_accept;
  logic             w_match;
  logic             w_addr_ok;
  logic             w_idle_hit;

  assign w_addr_ok = (32'(pat_addr) < 32'(SEQ_LEN));
  assign w_accept  = in_valid && !pat_we;

  // Candidate string: oldest history symbol at index 0, incoming symbol last.
  always_comb begin
    for (int m = 0; m < int'(HL); m++) begin
      w_s[m] = r_hist[m];
    end
    w_s[SEQ_LEN-1] = inp;
  end

  // w_ok[j]: the last j symbols of the candidate equal pattern[0..j-1].
  always_comb begin
    w_ok    = '0;
    w_ok[0] = 1'b1;
    for (int j = 1; j <= int'(SEQ_LEN); j++) begin
      w_ok[j] = 1'b1;
      for (int t = 0; t < j; t++) begin
        if (w_s[int'(SEQ_LEN) - j + t] != r_pat[t]) begin
          w_ok[j] = 1'b0;
        end
      end
    end
  end

  // Longest matching prefix reachable from k, and longest proper border for overlap.
  always_comb begin
    w_adv    = '0;
    w_border = '0;
    for (int j = 1; j <= int'(SEQ_LEN); j++) begin
      if (w_ok[j] && (j <= int'(r_k) + 1)) begin
        w_adv = PW'(j);
        if (j < int'(SEQ_LEN)) begin
          w_border = PW'(j);
        end
      end
    end
  end

  assign w_match = w_accept && (w_adv == PW'(SEQ_LEN));

  always_comb begin
    done   = 1'b0;
    detect = 2'd0;
    if (!rst && w_match) begin
      done   = 1'b1;
      detect = inp[0] ? 2'd2 : 2'd1;
    end
  end

`ifdef SEQ_DETECT_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] r_idle;

  assign w_idle_hit = !in_valid && !pat_we && (r_k != '0) && (r_idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if (in_valid || pat_we || (r_k == '0) || w_idle_hit) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^(32'(TIMEOUT));
  assign w_idle_hit       = 1'b0;
`endif

  // Next-state logic for the prefix length and history.
  always_comb begin
    w_k_nxt      = r_k;
    w_hist_clr   = 1'b0;
    w_hist_shift = 1'b0;
    if (pat_we) begin
      w_k_nxt    = '0;
      w_hist_clr = 1'b1;
    end else if (in_valid) begin
      if (w_match && (OVERLAP == 0)) begin
        w_k_nxt    = '0;
        w_hist_clr = 1'b1;
      end else if (w_match) begin
        w_k_nxt      = w_border;
        w_hist_shift = 1'b1;
      end else begin
        w_k_nxt      = w_adv;
        w_hist_shift = 1'b1;
      end
    end else if (w_idle_hit) begin
      w_k_nxt    = '0;
      w_hist_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k <= '0;
      for (int m = 0; m < int'(HL); m++) begin
        r_hist[m] <= '0;
      end
      for (int i = 0; i < int'(SEQ_LEN); i++) begin
        r_pat[i] <= PAT_INIT[i*SYM_W +: SYM_W];
      end
    end else begin
      r_k <= w_k_nxt;
      if (w_hist_clr) begin
        for (int m = 0; m < int'(HL); m++) begin
          r_hist[m] <= '0;
        end
      end else if (w_hist_shift) begin
        for (int m = 0; m < int'(HL) - 1; m++) begin
          r_hist[m] <= r_hist[m+1];
        end
        r_hist[HL-1] <= inp;
      end
      if (pat_we && w_addr_ok) begin
        r_pat[pat_addr] <= pat_wdata;
      end
    end
  end

  // Saturating match counter; clear wins over a same-cycle match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (done && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign progress  = r_k;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: scoreboard of expected done/detect/progress per driven symbol.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, pat_we, cnt_clr;
  logic [2:0] inp, pat_wdata;
  logic [1:0] pat_addr;

  logic       done0, done1;
  logic [1:0] det0, det1;
  logic [2:0] prog0, prog1;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       d;
    logic [1:0] det;
    logic [2:0] pr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .pat_we(pat_we),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .cnt_clr(cnt_clr),
    .done(done0), .detect(det0), .progress(prog0), .match_cnt(cnt0)
  );

  seq_detect_param #(.OVERLAP(0), .PAT_INIT(12'h249)) u_dut_no (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inp(inp), .pat_we(pat_we),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .cnt_clr(cnt_clr),
    .done(done1), .detect(det1), .progress(prog1), .match_cnt(cnt1)
  );

  // Drive one symbol, push its expectation, pop and compare against the selected DUT.
  task automatic step(input bit sel, input logic [2:0] s, input logic clr,
                      input logic ed, input logic [1:0] edet, input logic [2:0] epr,
                      input string nm);
    exp_t       e;
    logic       gd;
    logic [1:0] gdet;
    logic [2:0] gpr;
    @(negedge clk);
    in_valid = 1'b1;
    inp      = s;
    cnt_clr  = clr;
    q.push_back({ed, edet, epr});
    #1;
    e    = q.pop_front();
    gd   = sel ? done1 : done0;
    gdet = sel ? det1 : det0;
    checks++;
    if ({gd, gdet} !== {e.d, e.det}) begin
      errors++;
      $display("FAIL %s done/detect: got %b/%0d want %b/%0d", nm, gd, gdet, e.d, e.det);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    gpr = sel ? prog1 : prog0;
    checks++;
    if (gpr !== e.pr) begin
      errors++;
      $display("FAIL %s progress: got %0d want %0d", nm, gpr, e.pr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; pat_we = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_pat(input logic [2:0] p0, input logic [2:0] p1,
                          input logic [2:0] p2, input logic [2:0] p3);
    logic [2:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat_we = 1'b1; pat_addr = 2'(i); pat_wdata = p[i];
    end
    @(negedge clk);
    pat_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; pat_we = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; inp = 3'd0;
    #1;
    checks++;
    if (done0 !== 1'b0 || det0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%0d want 0/0", done0, det0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (prog0 !== 3'd0 || cnt0 !== 8'd0 || prog1 !== 3'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got prog %0d/%0d cnt %0d/%0d want 0", prog0, prog1, cnt0, cnt1);
    end
  endtask

  task automatic test_basic();
    step(0, 3'd0, 0, 0, 2'd0, 3'd1, "basic_s1");
    step(0, 3'd6, 0, 0, 2'd0, 3'd2, "basic_s2");
    step(0, 3'd4, 0, 0, 2'd0, 3'd3, "basic_s3");
    step(0, 3'd2, 0, 1, 2'd1, 3'd0, "basic_s4");
    checks++;
    if (cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL basic_cnt: got %0d want 1", cnt0);
    end
  endtask

  task automatic test_partial_restart();
    logic [2:0] s  [6] = '{3'd0, 3'd6, 3'd0, 3'd6, 3'd4, 3'd2};
    logic [2:0] pr [6] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 6; i++) begin
      step(0, s[i], 0, i == 5, (i == 5) ? 2'd1 : 2'd0, pr[i], $sformatf("restart_s%0d", i + 1));
    end
  endtask

  task automatic test_pattern_write();
    logic [7:0] c;
    step(0, 3'd0, 0, 0, 2'd0, 3'd1, "pw_pre1");
    step(0, 3'd6, 0, 0, 2'd0, 3'd2, "pw_pre2");
    step(0, 3'd4, 0, 0, 2'd0, 3'd3, "pw_pre3");
    c = cnt0;
    @(negedge clk);
    pat_we = 1'b1; pat_addr = 2'd0; pat_wdata = 3'd3; in_valid = 1'b1; inp = 3'd2;
    #1;
    checks++;
    if (done0 !== 1'b0 || det0 !== 2'd0) begin
      errors++;
      $display("FAIL pw_discard: got %b/%0d want 0/0", done0, det0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (prog0 !== 3'd0 || cnt0 !== c) begin
      errors++;
      $display("FAIL pw_clear: got prog %0d cnt %0d want prog 0 cnt %0d", prog0, cnt0, c);
    end
    load_pat(3'd3, 3'd5, 3'd7, 3'd1);
    step(0, 3'd3, 0, 0, 2'd0, 3'd1, "pw_s1");
    step(0, 3'd5, 0, 0, 2'd0, 3'd2, "pw_s2");
    step(0, 3'd7, 0, 0, 2'd0, 3'd3, "pw_s3");
    step(0, 3'd1, 0, 1, 2'd2, 3'd0, "pw_s4");
  endtask

  task automatic test_overlap();
    do_reset();
    load_pat(3'd1, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < 7; i++) begin
      step(0, 3'd1, 0, i >= 3, (i >= 3) ? 2'd2 : 2'd0, (i < 3) ? 3'(i + 1) : 3'd3,
           $sformatf("ovl_s%0d", i + 1));
    end
    checks++;
    if (cnt0 !== 8'd4) begin
      errors++;
      $display("FAIL ovl_cnt: got %0d want 4", cnt0);
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, 3'd1, 0, i == 3, (i == 3) ? 2'd2 : 2'd0,
           (i < 3) ? 3'(i + 1) : ((i == 3) ? 3'd0 : 3'(i - 3)), $sformatf("novl_s%0d", i + 1));
    end
    checks++;
    if (cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL novl_cnt: got %0d want 1", cnt1);
    end
  endtask

  task automatic test_saturate();
    int m = 0;
    do_reset();
    load_pat(3'd1, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < 262; i++) begin
      if (i >= 3 && m < 255) m++;
      step(0, 3'd1, 0, i >= 3, (i >= 3) ? 2'd2 : 2'd0, (i < 3) ? 3'(i + 1) : 3'd3, "sat_sym");
    end
    checks++;
    if (cnt0 !== 8'(m)) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want %0d", cnt0, m);
    end
  endtask

  task automatic test_cnt_clr();
    step(0, 3'd1, 1, 1, 2'd2, 3'd3, "clr_match");
    checks++;
    if (cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL clr_priority: got %0d want 0", cnt0);
    end
    step(0, 3'd1, 0, 1, 2'd2, 3'd3, "clr_after");
    checks++;
    if (cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL clr_after_cnt: got %0d want 1", cnt0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 3'd0, 0, 0, 2'd0, 3'd1, "rmid_s1");
    step(0, 3'd6, 0, 0, 2'd0, 3'd2, "rmid_s2");
    do_reset();
    checks++;
    if (prog0 !== 3'd0) begin
      errors++;
      $display("FAIL rmid_prog: got %0d want 0", prog0);
    end
    step(0, 3'd4, 0, 0, 2'd0, 3'd0, "rmid_s3");
    step(0, 3'd2, 0, 0, 2'd0, 3'd0, "rmid_s4");
    step(0, 3'd0, 0, 0, 2'd0, 3'd1, "rgate_s1");
    step(0, 3'd6, 0, 0, 2'd0, 3'd2, "rgate_s2");
    step(0, 3'd4, 0, 0, 2'd0, 3'd3, "rgate_s3");
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; inp = 3'd2;
    #1;
    checks++;
    if (done0 !== 1'b0 || det0 !== 2'd0) begin
      errors++;
      $display("FAIL rgate_outputs: got %b/%0d want 0/0", done0, det0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    step(0, 3'd0, 0, 0, 2'd0, 3'd1, "to16_s1");
    step(0, 3'd6, 0, 0, 2'd0, 3'd2, "to16_s2");
    step(0, 3'd4, 0, 0, 2'd0, 3'd3, "to16_s3");
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (prog0 !== (TO_EN ? 3'd0 : 3'd3)) begin
      errors++;
      $display("FAIL to16_prog: got %0d want %0d", prog0, TO_EN ? 0 : 3);
    end
    step(0, 3'd2, 0, !TO_EN, TO_EN ? 2'd0 : 2'd1, 3'd0, "to16_s4");
    step(0, 3'd0, 0, 0, 2'd0, 3'd1, "to15_s1");
    step(0, 3'd6, 0, 0, 2'd0, 3'd2, "to15_s2");
    step(0, 3'd4, 0, 0, 2'd0, 3'd3, "to15_s3");
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (prog0 !== 3'd3) begin
      errors++;
      $display("FAIL to15_prog: got %0d want 3", prog0);
    end
    step(0, 3'd2, 0, 1, 2'd1, 3'd0, "to15_s4");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pat_we = 1'b0; cnt_clr = 1'b0;
    inp = '0; pat_addr = '0; pat_wdata = '0;
    test_reset();
    test_basic();
    test_partial_restart();
    test_pattern_write();
    test_overlap();
    test_saturate();
    test_cnt_clr();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
